// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 serial register writer.
// Optional shadow-register feature in the top is enabled by MMC1_WR_SHADOW_EN.
package mmc1_pkg;

  typedef enum logic [1:0] {
    MMC1_CTRL = 2'd0,
    MMC1_CHR0 = 2'd1,
    MMC1_CHR1 = 2'd2,
    MMC1_PRG  = 2'd3
  } mmc1_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_WRITE,
    ST_GAP
  } wr_state_e;

  localparam logic [15:0] MMC1_BASE_ADDR    = 16'h8000;
  localparam logic [4:0]  MMC1_CTRL_RESET   = 5'b01100;
  localparam logic [7:0]  MMC1_SHRESET_DATA = 8'h80;
  localparam logic [2:0]  MMC1_BIT_LAST     = 3'd4;

  function automatic logic [15:0] mmc1_reg_addr(
    input mmc1_reg_e r
  );
    return MMC1_BASE_ADDR | {1'b0, r, 13'h0};
  endfunction

endpackage

// File: rtl/mmc1_serial_writer_m2_gen.sv
// M2 divider: M2_HALF clk low then M2_HALF clk high, low after reset.
// fall = M2 falls at the coming edge; upd = bus update point at the coming edge.
module m2_gen #(
  parameter int M2_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic m2,
  output logic fall,
  output logic upd
);

  localparam int PW = $clog2(2 * M2_HALF);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * M2_HALF - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(M2_HALF);

  if (M2_HALF < 2) begin : g_bad_half
    $error("m2_gen: M2_HALF must be >= 2");
  end

  logic [PW-1:0] ph_q, ph_d;
  logic          m2_q, m2_d;

  always_comb begin
    ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
    m2_d = (ph_d >= PH_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
      m2_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      m2_q <= m2_d;
    end
  end

  assign m2   = m2_q;
  assign fall = (ph_q == PH_LAST);
  assign upd  = (ph_q == '0);

endmodule

// File: rtl/mmc1_serial_writer.sv
// MMC1 serial-port initiator: one parallel register write -> 5 serial bus writes.
// Define MMC1_WR_SHADOW_EN to add shadow copies of the mapper registers.
module mmc1_serial_writer #(
  parameter int          M2_HALF    = 2,
  parameter int          GAP_CYCLES = 1,
  parameter logic [15:0] IDLE_ADDR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_shreset,
  input  logic [1:0]  req_reg,
  input  logic [4:0]  req_data,
  output logic        busy,
  output logic        done,
  output logic        m2,
  output logic [15:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_rw
`ifdef MMC1_WR_SHADOW_EN
  ,
  output logic [4:0]  shadow_ctrl,
  output logic [4:0]  shadow_chr0,
  output logic [4:0]  shadow_chr1,
  output logic [3:0]  shadow_prg
`endif
);

  import mmc1_pkg::*;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("mmc1_serial_writer: GAP_CYCLES must be >= 1");
  end

  logic fall, upd;

  m2_gen #(.M2_HALF(M2_HALF)) u_m2_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .m2   (m2),
    .fall (fall),
    .upd  (upd)
  );

  wr_state_e     state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          fin_q, fin_d;
  logic          start_q, start_d;
  logic          active_q, active_d;
  logic          shr_q, shr_d;
  mmc1_reg_e     reg_q, reg_d;
  logic [4:0]    data_q, data_d;
  logic          rw_q, rw_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic          done_q, done_d;

  logic       accept, last_w, wr_go, wr_new;
  logic [2:0] wr_bit;

  assign accept = req_valid & ~active_q;
  assign last_w = shr_q | (bit_q == MMC1_BIT_LAST);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gcnt_d   = gcnt_q;
    fin_d    = fin_q;
    start_d  = start_q | accept;
    active_d = accept | (active_q & ~done_q);
    shr_d    = shr_q;
    reg_d    = reg_q;
    data_d   = data_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    wr_go    = 1'b0;
    wr_new   = 1'b0;
    wr_bit   = bit_q;
    if (accept) begin
      shr_d  = req_shreset;
      reg_d  = mmc1_reg_e'(req_reg);
      data_d = req_data;
    end
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT_SLOT;
      ST_WAIT_SLOT: if (upd) begin
        wr_go  = 1'b1;
        wr_new = 1'b1;
        wr_bit = '0;
      end
      ST_WRITE: begin
        done_d = fall & last_w;
        if (upd) begin
          state_d = ST_GAP;
          gcnt_d  = '0;
          fin_d   = last_w;
          rw_d    = 1'b1;
          addr_d  = IDLE_ADDR;
          dout_d  = '0;
        end
      end
      ST_GAP: if (upd) begin
        if (gcnt_q != GAP_LAST) begin
          gcnt_d = gcnt_q + GW'(1);
        end else if (!fin_q) begin
          wr_go  = 1'b1;
          wr_bit = bit_q + 3'd1;
        end else if (start_q) begin
          wr_go  = 1'b1;
          wr_new = 1'b1;
          wr_bit = '0;
        end else if (accept) begin
          state_d = ST_WAIT_SLOT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every write slot is entered on an update point, so hold time is preserved.
    if (wr_go) begin
      state_d = ST_WRITE;
      bit_d   = wr_bit;
      rw_d    = 1'b0;
      addr_d  = shr_q ? MMC1_BASE_ADDR : mmc1_reg_addr(reg_q);
      dout_d  = shr_q ? MMC1_SHRESET_DATA : {7'b0, data_q[wr_bit]};
      if (wr_new) start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      gcnt_q   <= '0;
      fin_q    <= 1'b0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      shr_q    <= 1'b0;
      reg_q    <= MMC1_CTRL;
      data_q   <= '0;
      rw_q     <= 1'b1;
      addr_q   <= IDLE_ADDR;
      dout_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      gcnt_q   <= gcnt_d;
      fin_q    <= fin_d;
      start_q  <= start_d;
      active_q <= active_d;
      shr_q    <= shr_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
    end
  end

  assign req_ready    = ~active_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign cpu_rw       = rw_q;
  assign cpu_addr     = addr_q;
  assign cpu_data_out = dout_q;

`ifdef MMC1_WR_SHADOW_EN
  logic [4:0] sh_ctrl_q, sh_ctrl_d;
  logic [4:0] sh_chr0_q, sh_chr0_d;
  logic [4:0] sh_chr1_q, sh_chr1_d;
  logic [3:0] sh_prg_q, sh_prg_d;

  always_comb begin
    sh_ctrl_d = sh_ctrl_q;
    sh_chr0_d = sh_chr0_q;
    sh_chr1_d = sh_chr1_q;
    sh_prg_d  = sh_prg_q;
    if (done_d) begin
      if (shr_q) begin
        sh_ctrl_d = sh_ctrl_q | MMC1_CTRL_RESET;
      end else begin
        unique case (reg_q)
          MMC1_CTRL: sh_ctrl_d = data_q;
          MMC1_CHR0: sh_chr0_d = data_q;
          MMC1_CHR1: sh_chr1_d = data_q;
          MMC1_PRG:  sh_prg_d  = data_q[3:0];
          default:   sh_ctrl_d = sh_ctrl_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_ctrl_q <= MMC1_CTRL_RESET;
      sh_chr0_q <= '0;
      sh_chr1_q <= '0;
      sh_prg_q  <= '0;
    end else begin
      sh_ctrl_q <= sh_ctrl_d;
      sh_chr0_q <= sh_chr0_d;
      sh_chr1_q <= sh_chr1_d;
      sh_prg_q  <= sh_prg_d;
    end
  end

  assign shadow_ctrl = sh_ctrl_q;
  assign shadow_chr0 = sh_chr0_q;
  assign shadow_chr1 = sh_chr1_q;
  assign shadow_prg  = sh_prg_q;
`endif

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Bench for mmc1_serial_writer with a behavioural MMC1 mapper on the bus.
// Build with MMC1_WR_SHADOW_EN to exercise shadow registers and GAP_CYCLES=3.
module tb_mmc1_serial_writer;

`ifdef MMC1_WR_SHADOW_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_shreset = 1'b0;
  logic [1:0]  req_reg = '0;
  logic [4:0]  req_data = '0;
  logic        busy, done, m2, cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
`ifdef MMC1_WR_SHADOW_EN
  logic [4:0]  shadow_ctrl, shadow_chr0, shadow_chr1;
  logic [3:0]  shadow_prg;
`endif

  mmc1_serial_writer #(
    .M2_HALF   (2),
    .GAP_CYCLES(GAP),
    .IDLE_ADDR (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_shreset (req_shreset),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .busy        (busy),
    .done        (done),
    .m2          (m2),
    .cpu_addr    (cpu_addr),
    .cpu_data_out(cpu_data_out),
    .cpu_rw      (cpu_rw)
`ifdef MMC1_WR_SHADOW_EN
    ,
    .shadow_ctrl (shadow_ctrl),
    .shadow_chr0 (shadow_chr0),
    .shadow_chr1 (shadow_chr1),
    .shadow_prg  (shadow_prg)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Mapper model: serial shift port, ignores writes on back-to-back cycles.
  logic [4:0]  m_ctrl = 5'b01100;
  logic [4:0]  m_chr0 = '0, m_chr1 = '0, sr = '0;
  logic [3:0]  m_prg = '0;
  int          sc = 0, nwr = 0, rd_run = 0;
  bit          prev_wr = 1'b0;
  logic [15:0] wa [256];
  logic [7:0]  wd [256];
  int          wg [256];

  always @(negedge m2) if (rst_n) begin
    if (!cpu_rw) begin
      if (nwr < 256) begin
        wa[nwr] = cpu_addr;
        wd[nwr] = cpu_data_out;
        wg[nwr] = rd_run;
      end
      nwr++;
      rd_run = 0;
      if (!prev_wr) begin
        if (cpu_data_out[7]) begin
          sr = '0;
          sc = 0;
          m_ctrl = m_ctrl | 5'b01100;
        end else begin
          sr = {cpu_data_out[0], sr[4:1]};
          sc++;
          if (sc == 5) begin
            case (cpu_addr[14:13])
              2'd0: m_ctrl = sr;
              2'd1: m_chr0 = sr;
              2'd2: m_chr1 = sr;
              default: m_prg = sr[3:0];
            endcase
            sr = '0;
            sc = 0;
          end
        end
      end
      prev_wr = 1'b1;
    end else begin
      rd_run++;
      prev_wr = 1'b0;
    end
  end

  // Bus may only change one clk after M2 falls; also count done pulses.
  int          low_run = 0, hold_viol = 0, done_cnt = 0;
  logic [24:0] bus_prev = '0;
  always @(negedge clk) begin
    if (m2) low_run = 0;
    else low_run++;
    if (rst_n && ({cpu_rw, cpu_addr, cpu_data_out} != bus_prev) && low_run != 2)
      hold_viol++;
    bus_prev = {cpu_rw, cpu_addr, cpu_data_out};
    if (done) done_cnt++;
  end

  task automatic send(input bit shr, input logic [1:0] r, input logic [4:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_shreset = shr;
    req_reg = r;
    req_data = d;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_req(input string tag, input bit shr,
                         input logic [1:0] r, input logic [4:0] d);
    send(shr, r, d);
    wait_done(tag);
    wait_idle(tag);
  endtask

  initial begin
    int base, d0, rbad, n;
    logic [4:0] e;
    repeat (3) @(negedge clk);
    chk("rst_m2", 32'(m2), 32'd0);
    chk("rst_rw", 32'(cpu_rw), 32'd1);
    chk("rst_addr", 32'(cpu_addr), 32'h0000);
    chk("rst_data", 32'(cpu_data_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    #2 rst_n = 1'b1;

    // control <= 00011
    base = nwr;
    d0 = done_cnt;
    run_req("t1", 1'b0, 2'd0, 5'b00011);
    e = 5'b00011;
    chk("t1_nwr", 32'(nwr - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_d%0d", i), 32'(wd[base+i]), 32'(e[i]));
      chk($sformatf("t1_a%0d", i), 32'(wa[base+i]), 32'h8000);
    end
    chk("t1_ctrl", 32'(m_ctrl), 32'b00011);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // prg <= 0101, writes spaced by GAP read cycles
    base = nwr;
    run_req("t2", 1'b0, 2'd3, 5'b10101);
    chk("t2_nwr", 32'(nwr - base), 32'd5);
    chk("t2_addr", 32'(wa[base+4]), 32'hE000);
    for (int i = 1; i < 5; i++)
      chk($sformatf("t2_gap%0d", i), 32'(wg[base+i]), 32'(GAP));
    chk("t2_prg", 32'(m_prg), 32'b0101);

    // abort during 3rd write
    base = nwr;
    send(1'b0, 2'd0, 5'b11111);
    n = 0;
    while (!(nwr == base + 2 && !cpu_rw && !m2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ab_third_wr", 32'(cpu_rw), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_m2", 32'(m2), 32'd0);
    chk("ab_rw", 32'(cpu_rw), 32'd1);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_addr", 32'(cpu_addr), 32'h0000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    chk("ab_nwr", 32'(nwr - base), 32'd2);

    // shift reset
    base = nwr;
    run_req("t3", 1'b1, 2'd2, 5'b10101);
    chk("t3_nwr", 32'(nwr - base), 32'd1);
    chk("t3_addr", 32'(wa[base]), 32'h8000);
    chk("t3_data", 32'(wd[base]), 32'h80);
    chk("t3_ctrl", 32'(m_ctrl), 32'b01111);

    // back-to-back with valid held high
    @(negedge clk);
    req_valid = 1'b1;
    req_shreset = 1'b0;
    req_reg = 2'd1;
    req_data = 5'h1F;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_reg = 2'd2;
    req_data = 5'h0A;
    rbad = 0;
    n = 0;
    while (n < 500) begin
      if (req_ready) rbad++;
      if (done) break;
      @(negedge clk);
      n++;
    end
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_ready_low", 32'(rbad), 32'd0);
    @(negedge clk);
    chk("b2b_ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_ready_taken", 32'(req_ready), 32'd0);
    wait_done("b2b2");
    wait_idle("b2b2");
    chk("b2b_chr0", 32'(m_chr0), 32'h1F);
    chk("b2b_chr1", 32'(m_chr1), 32'h0A);

    run_req("t5a", 1'b0, 2'd0, 5'b01110);
    run_req("t5b", 1'b0, 2'd3, 5'b11001);
    chk("t5_ctrl", 32'(m_ctrl), 32'b01110);
    chk("t5_prg", 32'(m_prg), 32'b1001);
`ifdef MMC1_WR_SHADOW_EN
    chk("sh_ctrl", 32'(shadow_ctrl), 32'b01110);
    chk("sh_chr0", 32'(shadow_chr0), 32'h1F);
    chk("sh_chr1", 32'(shadow_chr1), 32'h0A);
    chk("sh_prg", 32'(shadow_prg), 32'b1001);
`endif
    chk("hold_viol", 32'(hold_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
